// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared widths, pipeline stage type and address decode helpers for imem_responder
//
// Purpose: fixes the bus widths used by the interface and the responder, and
// provides the address decode used to map a byte address onto a memory word.
// Ports: none (package).
package imem_pkg;

  // Bus widths. These are shared with imem_if, so they live here rather than
  // as module parameters.
  localparam int ARCH_LEN   = 32;
  localparam int INST_BITS  = 64;
  localparam int TAG_BITS   = 6;

  // Default memory geometry and timing; the responder exposes these as
  // overridable module parameters.
  localparam int                  DEPTH      = 1024;
  localparam logic [ARCH_LEN-1:0] BASE_ADDR  = 32'h8000_0000;
  localparam int                  LATENCY    = 2;
  localparam int                  FIFO_DEPTH = 4;

  localparam int WORD_BYTES = INST_BITS / 8;
  localparam int OFF_BITS   = $clog2(WORD_BYTES);
  localparam int IDX_BITS   = $clog2(DEPTH);

  // One slot of the read pipeline.
  typedef struct packed {
    logic                 valid;
    logic [TAG_BITS-1:0]  tag;
    logic [INST_BITS-1:0] data;
  } stage_t;

  // The offset is taken modulo 2^ARCH_LEN, so addresses below the base wrap to
  // huge offsets and fall out of range rather than aliasing onto low words.
  function automatic logic in_range(input logic [ARCH_LEN-1:0] addr,
                                    input logic [ARCH_LEN-1:0] base,
                                    input int unsigned         depth);
    logic [ARCH_LEN-1:0] off;
    logic [63:0]         lim;
    off = addr - base;
    lim = 64'(depth) << OFF_BITS;
    return (64'(off) < lim);
  endfunction

  // Word number of an address; the byte-within-word bits are discarded.
  function automatic logic [ARCH_LEN-1:0] word_index(input logic [ARCH_LEN-1:0] addr,
                                                     input logic [ARCH_LEN-1:0] base);
    logic [ARCH_LEN-1:0] off;
    off = addr - base;
    return off >> OFF_BITS;
  endfunction

endpackage

// File: rtl/imem_if.sv
// rtl/imem_if.sv - imem fetch/store request and response bundle
//
// Purpose: groups the request and response handshake signals of the core's
// instruction-memory port.
// Modports:
//   master - core side: drives requests and resp_ready, observes the rest
//   slave  - memory side: accepts requests, returns tagged responses
interface imem_if;

  logic                                imem_req_ready;
  logic                                imem_req_valid;
  logic                                imem_req_bits_store;
  logic [imem_pkg::ARCH_LEN-1:0]       imem_req_bits_address;
  logic [1:0]                          imem_req_bits_size;
  logic [imem_pkg::TAG_BITS-1:0]       imem_req_bits_tag;
  logic [imem_pkg::INST_BITS-1:0]      imem_req_bits_data;
  logic [imem_pkg::INST_BITS/8-1:0]    imem_req_bits_mask;
  logic                                imem_resp_ready;
  logic                                imem_resp_valid;
  logic [imem_pkg::TAG_BITS-1:0]       imem_resp_bits_tag;
  logic [imem_pkg::INST_BITS-1:0]      imem_resp_bits_data;

  modport master (
    input  imem_req_ready,
    output imem_req_valid, imem_req_bits_store, imem_req_bits_address,
           imem_req_bits_size, imem_req_bits_tag, imem_req_bits_data,
           imem_req_bits_mask, imem_resp_ready,
    input  imem_resp_valid, imem_resp_bits_tag, imem_resp_bits_data
  );

  modport slave (
    output imem_req_ready,
    input  imem_req_valid, imem_req_bits_store, imem_req_bits_address,
           imem_req_bits_size, imem_req_bits_tag, imem_req_bits_data,
           imem_req_bits_mask, imem_resp_ready,
    output imem_resp_valid, imem_resp_bits_tag, imem_resp_bits_data
  );

endinterface

// File: rtl/imem_resp_fifo.sv
// rtl/imem_resp_fifo.sv - synchronous response FIFO with registered outputs and occupancy count
//
// Purpose: holds completed responses until the consumer takes them.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   i_push      - write i_data this cycle (caller guarantees not full)
//   i_data      - entry to write
//   i_pop       - consumer takes the head this cycle (ignored when empty)
//   o_valid     - head entry present
//   o_data      - head entry, stable until popped
//   o_full      - all entries occupied
//   o_count     - number of occupied entries
module imem_resp_fifo #(
  parameter  int WIDTH = 70,
  parameter  int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_pop   = i_pop && (r_count != '0);
  assign o_valid = (r_count != '0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_count = r_count;

  // Storage is cleared too so the head reads as zero while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ptr_next(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_next(r_rd_ptr);
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(w_pop);
    end
  end

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction-memory responder with fixed latency and credit-limited issue
//
// Purpose: target side of the imem port. Reads and byte-masked writes happen
// at the accept edge; the response travels a fixed-latency pipeline into a
// response FIFO and is returned in order with the request tag.
// Ports:
//   clock  - clock
//   reset  - asynchronous active-low reset
//   imem   - imem_if slave modport (request and response handshakes)
//   idle   - nothing in flight and FIFO empty
module imem_responder
  import imem_pkg::*;
#(
  parameter int                  DEPTH      = imem_pkg::DEPTH,
  parameter logic [ARCH_LEN-1:0] BASE_ADDR  = imem_pkg::BASE_ADDR,
  parameter int                  LATENCY    = imem_pkg::LATENCY,
  parameter int                  FIFO_DEPTH = imem_pkg::FIFO_DEPTH
) (
  input  logic clock,
  input  logic reset,
  imem_if.slave imem,
  output logic idle
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [INST_BITS-1:0] r_mem [DEPTH];

  logic                 w_accept;
  logic                 w_dequeue;
  logic                 w_in_range;
  logic [IDX_W-1:0]     w_idx;
  logic [INST_BITS-1:0] w_rd_data;
  stage_t               w_stage_in;
  stage_t               w_fifo_in;
  logic [CNT_W-1:0]     w_inflight;
  logic [CNT_W-1:0]     w_fifo_count;
  logic [CNT_W-1:0]     w_outstanding;
  logic                 w_fifo_full;
  logic                 w_fifo_valid;
  logic [TAG_BITS+INST_BITS-1:0] w_fifo_head;

  assign w_accept   = imem.imem_req_valid && imem.imem_req_ready;
  assign w_dequeue  = w_fifo_valid && imem.imem_resp_ready;
  assign w_in_range = in_range(imem.imem_req_bits_address, BASE_ADDR, DEPTH);
  assign w_idx      = IDX_W'(word_index(imem.imem_req_bits_address, BASE_ADDR));

  // Every accepted request owns one FIFO slot from accept until dequeue, so
  // the FIFO cannot overflow. Only registered state feeds ready; holding it
  // low during reset keeps requests out while the pipeline is being cleared.
  assign w_outstanding       = w_inflight + w_fifo_count;
  assign imem.imem_req_ready = reset && (w_outstanding < CNT_W'(FIFO_DEPTH));
  assign idle                = (w_outstanding == '0);

  // Memory array carries no reset so its contents survive a reset pulse.
  always_ff @(posedge clock) begin
    if (w_accept && imem.imem_req_bits_store && w_in_range) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (imem.imem_req_bits_mask[b]) r_mem[w_idx][b*8 +: 8] <= imem.imem_req_bits_data[b*8 +: 8];
      end
    end
  end

  // Stores and out-of-range reads answer with zero data.
  assign w_rd_data = (!imem.imem_req_bits_store && w_in_range) ? r_mem[w_idx] : '0;

  always_comb begin
    w_stage_in       = '0;
    w_stage_in.valid = w_accept;
    w_stage_in.tag   = imem.imem_req_bits_tag;
    w_stage_in.data  = w_rd_data;
  end

  // Stage LATENCY is the FIFO write itself, so only LATENCY-1 register
  // stages sit between the accept edge and the enqueue edge.
  if (LATENCY == 1) begin : g_direct
    assign w_fifo_in  = w_stage_in;
    assign w_inflight = '0;
  end else begin : g_pipe
    stage_t r_stg [1:LATENCY-1];

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        for (int i = 1; i < LATENCY; i++) r_stg[i] <= '0;
      end else begin
        r_stg[1] <= w_stage_in;
        for (int i = 2; i < LATENCY; i++) r_stg[i] <= r_stg[i-1];
      end
    end

    always_comb begin
      w_inflight = '0;
      for (int i = 1; i < LATENCY; i++) w_inflight = w_inflight + CNT_W'(r_stg[i].valid);
    end

    assign w_fifo_in = r_stg[LATENCY-1];
  end

  imem_resp_fifo #(
    .WIDTH (TAG_BITS + INST_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clock),
    .rst_n   (reset),
    .i_push  (w_fifo_in.valid),
    .i_data  ({w_fifo_in.tag, w_fifo_in.data}),
    .i_pop   (w_dequeue),
    .o_valid (w_fifo_valid),
    .o_data  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_count (w_fifo_count)
  );

  assign imem.imem_resp_valid     = w_fifo_valid;
  assign imem.imem_resp_bits_tag  = w_fifo_head[TAG_BITS+INST_BITS-1:INST_BITS];
  assign imem.imem_resp_bits_data = w_fifo_head[INST_BITS-1:0];

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
    w_fifo_in.valid |-> !w_fifo_full);

  a_store_size: assert property (@(posedge clock) disable iff (!reset)
    (w_accept && imem.imem_req_bits_store) |-> (int'(imem.imem_req_bits_size) <= OFF_BITS));

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - self-checking bench for imem_responder
module tb_imem_responder;
  import imem_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic idle;

  imem_if bus();

  imem_responder dut (
    .clock (clock),
    .reset (reset),
    .imem  (bus),
    .idle  (idle)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] m_mem [1024];
  logic [69:0] exp_q [$];
  logic [69:0] got_q [$];
  bit          last_acc;

  // Reference: word-addressed memory, responses in acceptance order.
  function automatic void model_accept(bit st, logic [31:0] addr, logic [5:0] tag,
                                       logic [63:0] d, logic [7:0] m);
    logic [31:0] off;
    bit          inr;
    int          idx;
    off = addr - 32'h8000_0000;
    inr = (off < 32'd8192);
    idx = int'(off / 8) % 1024;
    if (st) begin
      if (inr) for (int b = 0; b < 8; b++) if (m[b]) m_mem[idx][8*b +: 8] = d[8*b +: 8];
      exp_q.push_back({tag, 64'd0});
    end else begin
      exp_q.push_back({tag, inr ? m_mem[idx] : 64'd0});
    end
  endfunction

  task automatic set_req(bit v, bit st, logic [31:0] a, logic [5:0] t, logic [63:0] d, logic [7:0] m);
    bus.imem_req_valid        = v;
    bus.imem_req_bits_store   = st;
    bus.imem_req_bits_address = a;
    bus.imem_req_bits_tag     = t;
    bus.imem_req_bits_data    = d;
    bus.imem_req_bits_mask    = m;
    bus.imem_req_bits_size    = 2'd3;
  endtask

  // One clock: record accept/dequeue as seen before the edge, then step past it.
  task automatic tick();
    logic [69:0] obs;
    last_acc = bus.imem_req_valid && bus.imem_req_ready;
    obs = {bus.imem_resp_bits_tag, bus.imem_resp_bits_data};
    if (bus.imem_resp_valid && bus.imem_resp_ready) got_q.push_back(obs);
    if (last_acc) model_accept(bus.imem_req_bits_store, bus.imem_req_bits_address,
                               bus.imem_req_bits_tag, bus.imem_req_bits_data, bus.imem_req_bits_mask);
    @(posedge clock);
    #1;
  endtask

  task automatic issue(bit st, logic [31:0] a, logic [5:0] t, logic [63:0] d, logic [7:0] m);
    int c = 0;
    set_req(1'b1, st, a, t, d, m);
    do begin tick(); c++; end while (!last_acc && c < 50);
    bus.imem_req_valid = 1'b0;
    if (!last_acc) begin
      n_tests++; n_fail++;
      $display("FAIL issue_timeout: tag %0d not accepted in %0d cycles", t, c);
    end
  endtask

  task automatic drain();
    int c = 0;
    bus.imem_resp_ready = 1'b1;
    while (got_q.size() < exp_q.size() && c < 200) begin tick(); c++; end
    if (got_q.size() < exp_q.size()) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: got %0d responses, required %0d", got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    @(posedge clock); #1;
    n_tests += 5;
    if (bus.imem_req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready: got %b required 0", bus.imem_req_ready); end
    if (bus.imem_resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b required 0", bus.imem_resp_valid); end
    if (bus.imem_resp_bits_tag !== 6'd0) begin n_fail++; $display("FAIL rst_tag: got %0d required 0", bus.imem_resp_bits_tag); end
    if (bus.imem_resp_bits_data !== 64'd0) begin n_fail++; $display("FAIL rst_data: got %h required 0", bus.imem_resp_bits_data); end
    if (idle !== 1'b1) begin n_fail++; $display("FAIL rst_idle: got %b required 1", idle); end
    reset = 1'b1;
    tick();
    n_tests += 2;
    if (bus.imem_req_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b required 1", bus.imem_req_ready); end
    if (idle !== 1'b1) begin n_fail++; $display("FAIL post_rst_idle: got %b required 1", idle); end
  endtask

  task automatic test_read_latency();
    logic [69:0] g, e;
    issue(1'b1, 32'h8000_0000, 6'd0, 64'hDEAD_BEEF_0000_0001, 8'hFF);
    drain();
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_tests++;
      if (g !== e) begin n_fail++; $display("FAIL lat_preload: got tag %0d data %h, required tag %0d data %h", g[69:64], g[63:0], e[69:64], e[63:0]); end
    end
    bus.imem_resp_ready = 1'b1;
    set_req(1'b1, 1'b0, 32'h8000_0000, 6'd5, 64'd0, 8'h00);
    tick();
    bus.imem_req_valid = 1'b0;
    n_tests++;
    if (bus.imem_resp_valid !== 1'b0) begin n_fail++; $display("FAIL lat_cycle1_valid: got %b required 0", bus.imem_resp_valid); end
    tick();
    n_tests += 4;
    if (bus.imem_resp_valid !== 1'b1) begin n_fail++; $display("FAIL lat_cycle2_valid: got %b required 1", bus.imem_resp_valid); end
    if (bus.imem_resp_bits_tag !== 6'd5) begin n_fail++; $display("FAIL lat_tag: got %0d required 5", bus.imem_resp_bits_tag); end
    if (bus.imem_resp_bits_data !== 64'hDEAD_BEEF_0000_0001) begin n_fail++; $display("FAIL lat_data: got %h required deadbeef00000001", bus.imem_resp_bits_data); end
    if (idle !== 1'b0) begin n_fail++; $display("FAIL lat_busy: got idle %b required 0", idle); end
    tick();
    n_tests++;
    if (idle !== 1'b1) begin n_fail++; $display("FAIL lat_idle_after: got %b required 1", idle); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_store_load();
    logic [69:0] g, e;
    issue(1'b1, 32'h8000_0008, 6'd3, 64'd0, 8'hFF);
    drain();
    got_q.delete(); exp_q.delete();
    issue(1'b1, 32'h8000_0008, 6'd1, 64'h1122_3344_5566_7788, 8'h0F);
    issue(1'b0, 32'h8000_0008, 6'd2, 64'd0, 8'h00);
    drain();
    n_tests += 2;
    g = (got_q.size() > 0) ? got_q[0] : 70'h0;
    if (g !== {6'd1, 64'd0}) begin n_fail++; $display("FAIL st_ack: got tag %0d data %h, required tag 1 data 0", g[69:64], g[63:0]); end
    g = (got_q.size() > 1) ? got_q[1] : 70'h0;
    if (g !== {6'd2, 64'h0000_0000_5566_7788}) begin n_fail++; $display("FAIL st_load: got tag %0d data %h, required tag 2 data 0000000055667788", g[69:64], g[63:0]); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_tests++;
      if (g !== e) begin n_fail++; $display("FAIL st_model: got tag %0d data %h, required tag %0d data %h", g[69:64], g[63:0], e[69:64], e[63:0]); end
    end
  endtask

  task automatic test_backpressure();
    logic [69:0] g, e;
    int k = 0;
    int c = 0;
    for (int w = 0; w < 16; w++) issue(1'b1, 32'h8000_0000 + 32'(w * 8), 6'(w), {$urandom, $urandom}, 8'hFF);
    drain();
    got_q.delete(); exp_q.delete();
    bus.imem_resp_ready = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      set_req(k < 6, 1'b0, 32'h8000_0000 + 32'(k * 8), 6'(10 + k), 64'd0, 8'h00);
      tick();
      if (last_acc) k++;
    end
    n_tests += 4;
    if (k !== 4) begin n_fail++; $display("FAIL bp_accepted: got %0d required 4", k); end
    if (bus.imem_req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low: got %b required 0", bus.imem_req_ready); end
    if (bus.imem_resp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_resp_valid: got %b required 1", bus.imem_resp_valid); end
    if (got_q.size() !== 0) begin n_fail++; $display("FAIL bp_no_resp: got %0d responses required 0", got_q.size()); end
    bus.imem_resp_ready = 1'b1;
    while ((k < 6 || got_q.size() < 6) && c < 60) begin
      set_req(k < 6, 1'b0, 32'h8000_0000 + 32'(k * 8), 6'(10 + k), 64'd0, 8'h00);
      tick();
      if (last_acc) k++;
      c++;
    end
    bus.imem_req_valid = 1'b0;
    n_tests++;
    if (got_q.size() !== 6) begin n_fail++; $display("FAIL bp_count: got %0d responses required 6", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_tests++;
      if (g !== e) begin n_fail++; $display("FAIL bp_order: got tag %0d data %h, required tag %0d data %h", g[69:64], g[63:0], e[69:64], e[63:0]); end
    end
  endtask

  task automatic test_random();
    logic [69:0] g, e;
    logic [31:0] a;
    for (int cyc = 0; cyc < 400; cyc++) begin
      n_tests += 2;
      if (bus.imem_req_ready !== (exp_q.size() < 4)) begin
        n_fail++; $display("FAIL rnd_ready: cycle %0d got %b required %b", cyc, bus.imem_req_ready, exp_q.size() < 4);
      end
      if (idle !== (exp_q.size() == 0)) begin
        n_fail++; $display("FAIL rnd_idle: cycle %0d got %b required %b", cyc, idle, exp_q.size() == 0);
      end
      case ($urandom_range(0, 11))
        0:       a = 32'h7FFF_FFF8;
        1:       a = 32'h8000_2000 + 32'($urandom_range(0, 63));
        default: a = 32'h8000_0000 + 32'($urandom_range(0, 15) * 8) + 32'($urandom_range(0, 7));
      endcase
      set_req($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3, a, 6'($urandom),
              {$urandom, $urandom}, 8'($urandom));
      bus.imem_resp_ready = ($urandom_range(0, 3) != 0);
      tick();
      while (got_q.size() > 0) begin
        g = got_q.pop_front(); n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL rnd_extra: unexpected tag %0d data %h", g[69:64], g[63:0]); end
        else begin
          e = exp_q.pop_front();
          if (g !== e) begin n_fail++; $display("FAIL rnd_resp: got tag %0d data %h, required tag %0d data %h", g[69:64], g[63:0], e[69:64], e[63:0]); end
        end
      end
    end
    bus.imem_req_valid = 1'b0;
    drain();
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_tests++;
      if (g !== e) begin n_fail++; $display("FAIL rnd_tail: got tag %0d data %h, required tag %0d data %h", g[69:64], g[63:0], e[69:64], e[63:0]); end
    end
  endtask

  task automatic test_out_of_range();
    logic [69:0] want [8];
    logic [69:0] g;
    want = '{{6'd20, 64'd0}, {6'd21, 64'd0}, {6'd22, 64'd0}, {6'd23, 64'd0},
             {6'd24, 64'd0}, {6'd25, 64'd0}, {6'd26, 64'hAAAA_0000_1111_2222},
             {6'd27, 64'hBBBB_3333_4444_5555}};
    issue(1'b1, 32'h8000_0000, 6'd20, 64'hAAAA_0000_1111_2222, 8'hFF);
    issue(1'b1, 32'h8000_1FF8, 6'd21, 64'hBBBB_3333_4444_5555, 8'hFF);
    issue(1'b1, 32'h7FFF_FFF8, 6'd22, 64'hCCCC_CCCC_CCCC_CCCC, 8'hFF);
    issue(1'b1, 32'h8000_2000, 6'd23, 64'hCCCC_CCCC_CCCC_CCCC, 8'hFF);
    issue(1'b0, 32'h7FFF_FFF8, 6'd24, 64'd0, 8'h00);
    issue(1'b0, 32'h8000_2000, 6'd25, 64'd0, 8'h00);
    issue(1'b0, 32'h8000_0000, 6'd26, 64'd0, 8'h00);
    issue(1'b0, 32'h8000_1FF8, 6'd27, 64'd0, 8'h00);
    drain();
    for (int i = 0; i < 8; i++) begin
      g = (got_q.size() > 0) ? got_q.pop_front() : 70'h0;
      n_tests++;
      if (g !== want[i]) begin n_fail++; $display("FAIL oor_%0d: got tag %0d data %h, required tag %0d data %h", i, g[69:64], g[63:0], want[i][69:64], want[i][63:0]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_async_reset();
    logic [69:0] g;
    issue(1'b1, 32'h8000_0010, 6'd30, 64'h0123_4567_89AB_CDEF, 8'hFF);
    drain();
    got_q.delete(); exp_q.delete();
    bus.imem_resp_ready = 1'b0;
    issue(1'b0, 32'h8000_0010, 6'd31, 64'd0, 8'h00);
    issue(1'b0, 32'h8000_0010, 6'd32, 64'd0, 8'h00);
    issue(1'b0, 32'h8000_0010, 6'd33, 64'd0, 8'h00);
    n_tests++;
    if (bus.imem_resp_valid !== 1'b1) begin n_fail++; $display("FAIL ar_pre_valid: got %b required 1", bus.imem_resp_valid); end
    #2 reset = 1'b0;
    #1;
    n_tests += 3;
    if (bus.imem_resp_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid: got %b required 0", bus.imem_resp_valid); end
    if (idle !== 1'b1) begin n_fail++; $display("FAIL ar_idle: got %b required 1", idle); end
    if (bus.imem_req_ready !== 1'b0) begin n_fail++; $display("FAIL ar_ready_in_rst: got %b required 0", bus.imem_req_ready); end
    reset = 1'b1;
    got_q.delete(); exp_q.delete();
    bus.imem_resp_ready = 1'b1;
    tick();
    n_tests += 2;
    if (bus.imem_req_ready !== 1'b1) begin n_fail++; $display("FAIL ar_ready_after: got %b required 1", bus.imem_req_ready); end
    if (bus.imem_resp_valid !== 1'b0) begin n_fail++; $display("FAIL ar_no_stale: got %b required 0", bus.imem_resp_valid); end
    issue(1'b0, 32'h8000_0010, 6'd9, 64'd0, 8'h00);
    drain();
    g = (got_q.size() > 0) ? got_q.pop_front() : 70'h0;
    n_tests++;
    if (g !== {6'd9, 64'h0123_4567_89AB_CDEF}) begin
      n_fail++; $display("FAIL ar_mem_kept: got tag %0d data %h, required tag 9 data 0123456789abcdef", g[69:64], g[63:0]);
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    set_req(1'b0, 1'b0, 32'd0, 6'd0, 64'd0, 8'h00);
    bus.imem_resp_ready = 1'b0;
    test_reset();
    test_read_latency();
    test_store_load();
    test_backpressure();
    test_random();
    test_out_of_range();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
